// File: rtl/siso_frame_rx.sv
// -----------------------------------------------------------------------------
// siso_frame_rx
//   Serial frame receiver that consumes the LSB-first output of a SISO shift
//   stage. A frame is: start bit (1), WIDTH data bits LSB first, an optional
//   even-parity bit, and a stop bit (0). Good words are presented on a held
//   valid/ready output register. Framing and parity failures are reported as
//   one-cycle pulses. Overwriting an unaccepted word sets a sticky overrun
//   flag.
//
// Parameters
//   WIDTH      data bits per frame (>= 2)
//   PARITY_EN  1: even-parity bit follows the data bits, 0: no parity bit
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active low
//   sin         in   serial line, idles at 0
//   sin_en      in   bit strobe; sin is sampled only when sin_en = 1
//   data        out  received word, held while data_valid = 1
//   data_valid  out  word available; held until accepted with data_ready
//   data_ready  in   consumer accepts data this cycle when data_valid = 1
//   busy        out  1 whenever a frame is in progress (state != IDLE)
//   frame_err   out  one-cycle pulse: stop bit sampled as 1
//   parity_err  out  one-cycle pulse: parity mismatch (PARITY_EN = 1 only)
//   overrun     out  sticky; a good word was loaded over an unaccepted one
// -----------------------------------------------------------------------------
module siso_frame_rx #(
  parameter int WIDTH     = 4,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_en,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Frame-tracking state
  state_t           r_state;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_par_bit;

  // Output-side registers
  logic [WIDTH-1:0] r_data;
  logic             r_data_valid;
  logic             r_frame_err;
  logic             r_parity_err;
  logic             r_overrun;
  // A good stop bit arms this; the word moves to r_data on the following edge.
  logic             r_load;

  // Next-state values
  state_t           w_state_nxt;
  logic [CW-1:0]    w_bit_cnt_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             w_par_bit_nxt;
  logic             w_frame_err_nxt;
  logic             w_parity_err_nxt;
  logic             w_load_nxt;
  logic             w_par_bad;

  // Even parity over data plus parity bit must reduce to 0.
  assign w_par_bad = PARITY_EN & (^{r_shreg, r_par_bit});

  // ---------------------------------------------------------------------------
  // Next-state logic. Everything here only moves on a bit strobe.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shreg_nxt      = r_shreg;
    w_par_bit_nxt    = r_par_bit;
    w_frame_err_nxt  = 1'b0;
    w_parity_err_nxt = 1'b0;
    w_load_nxt       = 1'b0;

    if (sin_en) begin
      unique case (r_state)
        IDLE: begin
          if (sin) begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = '0;
          end
        end

        DATA: begin
          // Shift right so the first bit received ends up in bit 0.
          w_shreg_nxt = {sin, r_shreg[WIDTH-1:1]};
          if (r_bit_cnt == LAST) begin
            w_state_nxt = PARITY_EN ? PARITY : STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end

        PARITY: begin
          w_par_bit_nxt = sin;
          w_state_nxt   = STOP;
        end

        STOP: begin
          w_state_nxt = IDLE;
          // A bad stop bit masks any parity problem in the same frame.
          if (sin) begin
            w_frame_err_nxt = 1'b1;
          end else if (w_par_bad) begin
            w_parity_err_nxt = 1'b1;
          end else begin
            w_load_nxt = 1'b1;
          end
        end

        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers and output handshake.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    if (!rst) begin
      r_state      <= IDLE;
      r_bit_cnt    <= '0;
      r_shreg      <= '0;
      r_par_bit    <= 1'b0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
      r_load       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shreg      <= w_shreg_nxt;
      r_par_bit    <= w_par_bit_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_load       <= w_load_nxt;

      // The handshake runs every cycle, regardless of sin_en. r_shreg is
      // stable here because the FSM sits in IDLE right after a stop bit and
      // IDLE never shifts.
      if (r_load) begin
        r_data       <= r_shreg;
        r_data_valid <= 1'b1;
        if (r_data_valid && !data_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (r_data_valid && data_ready) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign busy       = (r_state != IDLE);
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_siso_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_siso_frame_rx
//   Directed bench for siso_frame_rx with WIDTH = 4, PARITY_EN = 1. Inputs are
//   driven 1 ns after each rising edge and outputs are sampled at that same
//   point, well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_siso_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       sin_en;
  logic [3:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  siso_frame_rx #(
    .WIDTH     (4),
    .PARITY_EN (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_en     (sin_en),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobed bit.
  task automatic send_bit(input logic b);
    sin    = b;
    sin_en = 1'b1;
    tick();
  endtask

  // Full frame: start, 4 data bits LSB first, parity, stop. Line returns to 0.
  task automatic send_frame(input logic [3:0] d, input logic par, input logic stop);
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    sin = 1'b0;
  endtask

  // Strobed bit followed by two unstrobed cycles where sin carries the
  // opposite value, which must be ignored.
  task automatic send_gap_bit(input string tag, input logic b, input logic exp_busy);
    send_bit(b);
    sin_en = 1'b0;
    sin    = ~b;
    tick();
    check(tag, busy, exp_busy);
    tick();
    check(tag, busy, exp_busy);
  endtask

  initial begin
    rst        = 1'b0;
    sin        = 1'b0;
    sin_en     = 1'b1;
    data_ready = 1'b0;

    // 1: reset held for two clocks, then idle line.
    tick();
    tick();
    check("rst_data",       data,       4'h0);
    check("rst_valid",      data_valid, 1'b0);
    check("rst_busy",       busy,       1'b0);
    check("rst_frame_err",  frame_err,  1'b0);
    check("rst_parity_err", parity_err, 1'b0);
    check("rst_overrun",    overrun,    1'b0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_busy", busy, 1'b0);
    end

    // 2: good frame 0xD with ready high; valid lasts exactly one cycle.
    data_ready = 1'b1;
    send_bit(1'b1);
    check("good_busy_after_start", busy, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(i == 1 ? 1'b0 : 1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    sin = 1'b0;
    check("good_busy_after_stop",   busy,       1'b0);
    check("good_valid_not_yet",     data_valid, 1'b0);
    check("good_no_frame_err",      frame_err,  1'b0);
    check("good_no_parity_err",     parity_err, 1'b0);
    tick();
    check("good_valid",             data_valid, 1'b1);
    check("good_data",              data,       4'hD);
    tick();
    check("good_valid_one_cycle",   data_valid, 1'b0);
    check("good_no_overrun",        overrun,    1'b0);

    // 3a: bad stop bit.
    send_frame(4'h3, 1'b0, 1'b1);
    check("ferr_pulse",        frame_err,  1'b1);
    check("ferr_no_perr",      parity_err, 1'b0);
    tick();
    check("ferr_pulse_ends",   frame_err,  1'b0);
    check("ferr_no_valid",     data_valid, 1'b0);
    check("ferr_data_kept",    data,       4'hD);

    // 3b: wrong parity bit.
    send_frame(4'hD, 1'b0, 1'b0);
    check("perr_pulse",        parity_err, 1'b1);
    check("perr_no_ferr",      frame_err,  1'b0);
    tick();
    check("perr_pulse_ends",   parity_err, 1'b0);
    check("perr_no_valid",     data_valid, 1'b0);
    check("perr_data_kept",    data,       4'hD);

    // 3c: both wrong; only the framing error is reported.
    send_frame(4'hD, 1'b0, 1'b1);
    check("both_ferr",         frame_err,  1'b1);
    check("both_no_perr",      parity_err, 1'b0);
    tick();

    // 4: backpressure, second word overwrites the first.
    data_ready = 1'b0;
    send_frame(4'hD, 1'b1, 1'b0);
    tick();
    check("bp_first_valid",    data_valid, 1'b1);
    check("bp_first_data",     data,       4'hD);
    check("bp_first_overrun",  overrun,    1'b0);
    send_frame(4'h3, 1'b0, 1'b0);
    check("bp_held_data",      data,       4'hD);
    tick();
    check("bp_second_data",    data,       4'h3);
    check("bp_second_valid",   data_valid, 1'b1);
    check("bp_overrun",        overrun,    1'b1);
    data_ready = 1'b1;
    tick();
    check("bp_valid_drops",    data_valid, 1'b0);
    check("bp_overrun_sticky", overrun,    1'b1);
    tick();
    check("ready_ignored",     data_valid, 1'b0);

    // 5: strobe only every third clock while sending 0xA.
    data_ready = 1'b0;
    send_gap_bit("gap_start", 1'b1, 1'b1);
    send_gap_bit("gap_d0",    1'b0, 1'b1);
    send_gap_bit("gap_d1",    1'b1, 1'b1);
    send_gap_bit("gap_d2",    1'b0, 1'b1);
    send_gap_bit("gap_d3",    1'b1, 1'b1);
    send_gap_bit("gap_par",   1'b0, 1'b1);
    send_bit(1'b0);
    check("gap_busy_after_stop", busy, 1'b0);
    sin_en = 1'b0;
    sin    = 1'b1;
    tick();
    check("gap_valid",         data_valid, 1'b1);
    check("gap_data",          data,       4'hA);
    check("gap_no_start",      busy,       1'b0);
    sin        = 1'b0;
    data_ready = 1'b1;
    tick();
    check("gap_valid_drops",   data_valid, 1'b0);

    // 6: reset in the middle of a frame, then a clean frame 0x5.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    check("mid_busy",          busy, 1'b1);
    rst = 1'b0;
    sin = 1'b0;
    tick();
    check("mid_rst_busy",      busy,       1'b0);
    check("mid_rst_overrun",   overrun,    1'b0);
    check("mid_rst_data",      data,       4'h0);
    rst = 1'b1;
    tick();
    check("mid_no_ferr",       frame_err,  1'b0);
    check("mid_no_perr",       parity_err, 1'b0);
    check("mid_no_valid",      data_valid, 1'b0);
    send_frame(4'h5, 1'b0, 1'b0);
    tick();
    check("mid_next_valid",    data_valid, 1'b1);
    check("mid_next_data",     data,       4'h5);

    // 7: load in the same cycle the old word is accepted: no overrun.
    data_ready = 1'b0;
    send_frame(4'hA, 1'b0, 1'b0);
    check("swap_old_held",     data,       4'h5);
    data_ready = 1'b1;
    tick();
    check("swap_data",         data,       4'hA);
    check("swap_valid",        data_valid, 1'b1);
    check("swap_no_overrun",   overrun,    1'b0);
    tick();
    check("swap_valid_drops",  data_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
